// File: rtl/biquad_cascade_tdm.sv
// Cascade of SECTIONS direct-form-I biquads sharing one time-multiplexed MAC.
// Coefficients live in a double-buffered bank (shadow written any time, active
// copied only between samples). Define SATURATE_EN to clamp each section
// result to the N-bit range; otherwise results wrap in two's complement.
module biquad_cascade_tdm #(
    parameter int unsigned decim    = 14,
    parameter int unsigned magn     = 8,
    parameter int unsigned N        = decim + magn + 1,
    parameter int unsigned SECTIONS = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            gen_enable,
    input  logic [N-1:0]                    DataIn,
    input  logic                            coef_we,
    input  logic [$clog2(5*SECTIONS)-1:0]   coef_addr,
    input  logic [N-1:0]                    coef_wdata,
    input  logic                            coef_commit,
    output logic [N-1:0]                    DataOut,
    output logic                            data_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int unsigned NC  = 5 * SECTIONS;
    localparam int unsigned CW  = $clog2(NC);
    localparam int unsigned SW  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int unsigned PW  = 2 * N;
    localparam int unsigned ACW = 2 * N + 3;
    localparam logic [N-1:0] ONE = N'(2 ** decim);

    typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

    state_t state, state_next;
    logic   busy_next, valid_next, overrun_next;

    logic [2:0]    step;
    logic [SW-1:0] section;
    logic          last_sec;
    logic          pending;
    logic          copy_now;
    logic          wr_ok;
    logic [CW-1:0] coef_idx;

    logic signed [N-1:0]   shadow [NC];
    logic signed [N-1:0]   active [NC];
    logic signed [N-1:0]   x1 [SECTIONS];
    logic signed [N-1:0]   x2 [SECTIONS];
    logic signed [N-1:0]   y1 [SECTIONS];
    logic signed [N-1:0]   y2 [SECTIONS];
    logic signed [N-1:0]   cur_x;
    logic signed [N-1:0]   coef_sel;
    logic signed [N-1:0]   data_sel;
    logic signed [PW-1:0]  prod;
    logic signed [ACW-1:0] prod_ext;
    logic signed [ACW-1:0] acc;
    logic signed [N-1:0]   y_c;

    assign last_sec = (32'(section) == SECTIONS - 1);
    assign wr_ok    = coef_we && ({1'b0, coef_addr} < (CW+1)'(NC));
    assign copy_now = (pending || coef_commit) && (state == IDLE) && !gen_enable;
    assign coef_idx = CW'(5 * 32'(section) + 32'(step));

    // Operand select for the shared multiplier: step walks b0,b1,b2,a1,a2.
    always_comb begin
        coef_sel = active[coef_idx];
        case (step)
            3'd0:    data_sel = cur_x;
            3'd1:    data_sel = x1[section];
            3'd2:    data_sel = x2[section];
            3'd3:    data_sel = y1[section];
            default: data_sel = y2[section];
        endcase
        prod     = PW'(coef_sel) * PW'(data_sel);
        prod_ext = ACW'(prod);
    end

`ifdef SATURATE_EN
    localparam logic signed [ACW-1:0] SAT_MAX = ACW'((2 ** (N - 1)) - 1);
    localparam logic signed [ACW-1:0] SAT_MIN = -SAT_MAX - ACW'(1);
    logic signed [ACW-1:0] shifted;

    // Floor-shift the accumulator and clamp into the N-bit range.
    always_comb begin
        shifted = acc >>> decim;
        if (shifted > SAT_MAX)
            y_c = SAT_MAX[N-1:0];
        else if (shifted < SAT_MIN)
            y_c = SAT_MIN[N-1:0];
        else
            y_c = shifted[N-1:0];
    end
`else
    // Floor-shift the accumulator and keep the low N bits.
    always_comb begin
        y_c = N'(acc >>> decim);
    end
`endif

    // FSM state and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_next;
            busy       <= busy_next;
            data_valid <= valid_next;
            overrun    <= overrun_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        busy_next    = busy;
        valid_next   = 1'b0;
        overrun_next = overrun || (gen_enable && (state != IDLE));
        case (state)
            IDLE: begin
                if (gen_enable) begin
                    state_next = MAC;
                    busy_next  = 1'b1;
                end
            end
            MAC: begin
                if (step == 3'd4)
                    state_next = WRITE;
            end
            WRITE: begin
                state_next = last_sec ? DONE : MAC;
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                valid_next = 1'b1;
            end
        endcase
    end

    // MAC datapath, per-section history and output register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            step    <= '0;
            section <= '0;
            acc     <= '0;
            cur_x   <= '0;
            DataOut <= '0;
            for (int unsigned i = 0; i < SECTIONS; i++) begin
                x1[i] <= '0;
                x2[i] <= '0;
                y1[i] <= '0;
                y2[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (gen_enable) begin
                        cur_x   <= DataIn;
                        step    <= '0;
                        section <= '0;
                    end
                end
                MAC: begin
                    acc  <= (step == 3'd0) ? prod_ext : acc + prod_ext;
                    step <= (step == 3'd4) ? 3'd0 : step + 3'd1;
                end
                WRITE: begin
                    x1[section] <= cur_x;
                    x2[section] <= x1[section];
                    y1[section] <= y_c;
                    y2[section] <= y1[section];
                    cur_x       <= y_c;
                    if (!last_sec)
                        section <= section + SW'(1);
                end
                default: begin
                    DataOut <= cur_x;
                end
            endcase
        end
    end

    // Shadow/active coefficient banks; a same-cycle write is folded into the copy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= 1'b0;
            for (int unsigned i = 0; i < NC; i++) begin
                shadow[i] <= (i % 5 == 0) ? ONE : '0;
                active[i] <= (i % 5 == 0) ? ONE : '0;
            end
        end else begin
            if (wr_ok)
                shadow[coef_addr] <= coef_wdata;
            if (copy_now) begin
                for (int unsigned i = 0; i < NC; i++)
                    active[i] <= (wr_ok && (coef_addr == CW'(i))) ? coef_wdata : shadow[i];
            end
            pending <= (pending || coef_commit) && !copy_now;
        end
    end

endmodule

// File: tb/tb_biquad_cascade_tdm.sv
// Scoreboard bench for biquad_cascade_tdm (default parameters, SECTIONS=2).
module tb_biquad_cascade_tdm;

    localparam int unsigned N  = 23;
    localparam int unsigned AW = 4;

    logic          clock;
    logic          reset;
    logic          gen_enable;
    logic [N-1:0]  DataIn;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [N-1:0]  coef_wdata;
    logic          coef_commit;
    logic [N-1:0]  DataOut;
    logic          data_valid;
    logic          busy;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [N-1:0] exp_q[$];
    int           t_q[$];
    logic [N-1:0] exp_v;
    int           t_v;

    biquad_cascade_tdm dut (
        .clock       (clock),
        .reset       (reset),
        .gen_enable  (gen_enable),
        .DataIn      (DataIn),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_wdata  (coef_wdata),
        .coef_commit (coef_commit),
        .DataOut     (DataOut),
        .data_valid  (data_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pop and compare every produced sample, including its latency.
    always begin
        @(posedge clock);
        #1;
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                t_v   = t_q.pop_front();
                check("dataout", 32'(DataOut), 32'(exp_v));
                check("latency", 32'(cyc - t_v), 32'd13);
            end
        end
    end

    task automatic send(input logic [N-1:0] d, input logic [N-1:0] e);
        DataIn     = d;
        gen_enable = 1'b1;
        exp_q.push_back(e);
        t_q.push_back(cyc + 1);
        @(negedge clock);
        gen_enable = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] d);
        DataIn     = d;
        gen_enable = 1'b1;
        @(negedge clock);
        gen_enable = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            t_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic wcoef(input logic [AW-1:0] a, input logic [N-1:0] d, input logic c);
        coef_addr   = a;
        coef_wdata  = d;
        coef_we     = 1'b1;
        coef_commit = c;
        @(negedge clock);
        coef_we     = 1'b0;
        coef_commit = 1'b0;
    endtask

    task automatic commit();
        coef_commit = 1'b1;
        @(negedge clock);
        coef_commit = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b0;
        gen_enable  = 1'b0;
        DataIn      = '0;
        coef_we     = 1'b0;
        coef_addr   = '0;
        coef_wdata  = '0;
        coef_commit = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_dataout", 32'(DataOut), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Passthrough, then a second sample at the maximum rate.
        send(23'h004000, 23'h004000);
        check("busy_high", 32'(busy), 32'd1);
        repeat (13) @(negedge clock);
        send(23'h001234, 23'h001234);
        drain();
        check("no_overrun_max_rate", 32'(overrun), 32'd0);
        check("busy_low", 32'(busy), 32'd0);

        // Gain programming: shadow write has no effect until commit.
        wcoef(4'd0, 23'h002000, 1'b0);
        repeat (2) @(negedge clock);
        send(23'h004000, 23'h004000);
        drain();
        commit();
        repeat (2) @(negedge clock);
        send(23'h004000, 23'h002000);
        drain();
        wcoef(4'd15, 23'h000000, 1'b1);
        repeat (2) @(negedge clock);
        send(23'h004000, 23'h002000);
        drain();

        // Recursion via a1 = 0.5, written and committed in the same cycle.
        do_reset();
        wcoef(4'd3, 23'h002000, 1'b1);
        repeat (2) @(negedge clock);
        send(23'h004000, 23'h004000);
        drain();
        send(23'h000000, 23'h002000);
        drain();
        send(23'h000000, 23'h001000);
        drain();
        send(23'h000000, 23'h000800);
        drain();

        // Gain of 2.0 at both ends of the range.
        do_reset();
        wcoef(4'd0, 23'h008000, 1'b1);
        repeat (2) @(negedge clock);
`ifdef SATURATE_EN
        send(23'h3FFFFF, 23'h3FFFFF);
        drain();
        send(23'h400000, 23'h400000);
        drain();
`else
        send(23'h3FFFFF, 23'h7FFFFE);
        drain();
        send(23'h400000, 23'h000000);
        drain();
`endif

        // Floor rounding of a negative half.
        do_reset();
        wcoef(4'd0, 23'h002000, 1'b1);
        repeat (2) @(negedge clock);
        send(23'h7FFFFF, 23'h7FFFFF);
        drain();

        // Overrun: second strobe five cycles into a computation.
        do_reset();
        check("overrun_clear", 32'(overrun), 32'd0);
        send(23'h004000, 23'h004000);
        repeat (4) @(negedge clock);
        pulse(23'h001111);
        check("overrun_set", 32'(overrun), 32'd1);
        drain();
        repeat (10) @(negedge clock);
        check("overrun_held", 32'(overrun), 32'd1);
        send(23'h002000, 23'h002000);
        drain();
        check("overrun_still", 32'(overrun), 32'd1);

        // Reset at cycle 7 of a computation with a pending commit in flight.
        pulse(23'h004000);
        wcoef(4'd0, 23'h001000, 1'b1);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("midrst_dataout", 32'(DataOut), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        send(23'h004000, 23'h004000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biquad_cascade_tdm.md
Name: biquad_cascade_tdm

Overview:
- Parametrised cascade of SECTIONS direct-form-I biquads for the equaliser band filters.
- A single time-multiplexed multiplier-accumulator serves all sections.
- Coefficients are run-time programmable through a double-buffered register bank.
- One new sample per gen_enable strobe; sits between the audio sample source and the band gain/mix stage.

Parameters:
decim, 14, fractional bits of data and coefficients
magn, 8, integer magnitude bits
N, decim+magn+1, data/coefficient word width (signed two's complement)
SECTIONS, 2, number of cascaded biquads (1..8)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
gen_enable  in  1  sample strobe, one-cycle pulse per audio sample
DataIn  in  N  signed input sample
coef_we  in  1  write strobe into shadow coefficient bank
coef_addr  in  $clog2(5*SECTIONS)  address = 5*section + idx; idx 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
coef_wdata  in  N  coefficient value; a1/a2 stored pre-negated
coef_commit  in  1  request shadow-to-active bank copy
DataOut  out  N  signed filtered sample
data_valid  out  1  one-cycle pulse when DataOut updates
busy  out  1  high while a sample is being computed
overrun  out  1  sticky: gen_enable arrived while busy

Behaviour:
- Reset (async, active-low) sets DataOut=0, data_valid=0, busy=0, overrun=0 and all history (x1,x2,y1,y2 per section) to 0. Both banks reset to passthrough: b0=2^decim (1.0), all others 0.
- Per section: y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2. Section k output is section k+1 input.
- Products are 2N bits; accumulator is 2N+3 bits; result = accumulator arithmetic-shifted right by decim (floor), then reduced to N bits (see Optional Feature).
- FSM states:
  - IDLE: on gen_enable, latch DataIn, section=0, step=0, busy=1, go MAC.
  - MAC: one product per cycle, step 0..4 (b0,b1,b2,a1,a2 order), then go WRITE.
  - WRITE: 1 cycle. Form y; x2<=x1, x1<=x, y2<=y1, y1<=y. If section<SECTIONS-1, y becomes next input, section++, return to MAC; else go DONE.
  - DONE: 1 cycle. DataOut<=y, data_valid=1, busy=0, go IDLE.
- Latency: 6*SECTIONS+1 cycles from the gen_enable edge to the data_valid cycle (13 for SECTIONS=2). Throughput: at most one sample per 6*SECTIONS+2 cycles.
- gen_enable while busy: the sample is dropped, overrun set to 1 and held until reset; the computation in flight is unaffected.
- coef_we: writes the shadow bank on any cycle, including while busy. Addresses >= 5*SECTIONS are ignored.
- coef_commit: latched as pending. The copy to the active bank happens on the first cycle with FSM in IDLE and no gen_enable, and the pending flag clears then. Each sample always uses one consistent coefficient set.
- coef_we and coef_commit in the same cycle: the write lands first, and the commit copies it.
- Reset mid-computation: FSM returns to IDLE, no data_valid is produced, and the pending commit is discarded.

Optional Feature:
- SATURATE_EN defined: the shifted result is clamped to [-2^(N-1), 2^(N-1)-1] before storing as y and as section output.
- SATURATE_EN not defined: the low N bits are kept (two's-complement wrap).

Test Plan:
- Passthrough after reset: DataIn=0x004000 with gen_enable -> data_valid exactly 13 cycles later, DataOut=0x004000.
- Gain program: write addr0 (section0 b0)=0x002000, commit, DataIn=0x004000 -> DataOut=0x002000. Before commit, the same input -> 0x004000.
- Recursion: section0 b0=0x004000, a1=0x002000; impulse 0x004000 then zeros -> DataOut 0x004000, 0x002000, 0x001000, 0x000800.
- Saturation: section0 b0=0x008000, DataIn=0x3FFFFF -> with SATURATE_EN DataOut=0x3FFFFF; without it DataOut=0x7FFFFE.
- Overrun: second gen_enable 5 cycles after the first -> only one data_valid, overrun=1 and held.
- Reset asserted at cycle 7 of a computation -> no data_valid, DataOut=0. The next sample 0x004000 -> 0x004000 with history cleared.
